// File: rtl/dispensadora_multiproducto_pkg.sv
// vending_pkg: shared state encoding, default widths and price-table slicing
package vending_pkg;
    localparam int N_PROD_DEF   = 4;
    localparam int CREDIT_W_DEF = 8;
    localparam int TBL_MAX      = 256;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CREDIT   = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4,
        S_REFUND   = 3'd5
    } state_e;
    // price of entry idx in a packed table of w-bit prices
    function automatic logic [31:0] price_at(input logic [TBL_MAX-1:0] tbl, input int idx, input int w);
        return 32'(tbl >> (idx * w)) & ~(32'hffff_ffff << w);
    endfunction
endpackage

// File: rtl/dispensadora_multiproducto_if.sv
// dispensadora_multiproducto_if: coin/keypad/valve bundle of the vending controller
// master drives coins, selection, cancel, prices, stock and water; slave drives
// dispense, change, reject/insufficient pulses, credit and busy.
interface dispensadora_multiproducto_if import vending_pkg::*; #(
    parameter int N_PROD   = N_PROD_DEF,
    parameter int CREDIT_W = CREDIT_W_DEF
);
    localparam int SEL_W = $clog2(N_PROD);
    logic                       coin_valid;
    logic [CREDIT_W-1:0]        coin_value;
    logic                       sel_valid;
    logic [SEL_W-1:0]           sel_idx;
    logic                       cancel;
    logic [N_PROD*CREDIT_W-1:0] price_tbl;
    logic [N_PROD-1:0]          stock_ok;
    logic                       water_ok;
    logic [N_PROD-1:0]          dispense;
    logic                       change_valid;
    logic [CREDIT_W-1:0]        change_amt;
    logic                       coin_reject;
    logic                       insufficient;
    logic [CREDIT_W-1:0]        credit;
    logic                       busy;
    modport master (
        output coin_valid, coin_value, sel_valid, sel_idx, cancel, price_tbl, stock_ok, water_ok,
        input  dispense, change_valid, change_amt, coin_reject, insufficient, credit, busy
    );
    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_idx, cancel, price_tbl, stock_ok, water_ok,
        output dispense, change_valid, change_amt, coin_reject, insufficient, credit, busy
    );
endinterface

// File: rtl/dispensadora_multiproducto_temporizador.sv
// temporizador_inactividad: down-counter that flags expiry after COUNT enabled cycles
// clear reloads, enable counts down, expired is high while the count is zero.
module temporizador_inactividad #(
    parameter int COUNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(COUNT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? W'(COUNT - 1) : (enable && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= W'(COUNT - 1);
        else      cnt_q <= cnt_d;
    end
    assign expired = cnt_q == '0;
endmodule

// File: rtl/dispensadora_multiproducto.sv
// dispensadora_multiproducto: multi-product vending FSM with credit, change and refunds
// clk, rst (async active-low) and the slave side of dispensadora_multiproducto_if.
module dispensadora_multiproducto import vending_pkg::*; #(
    parameter int N_PROD      = N_PROD_DEF,
    parameter int CREDIT_W    = CREDIT_W_DEF,
    parameter int MAX_CREDIT  = 200,
    parameter int DISP_CYCLES = 16,
    parameter int TIMEOUT     = 1000
) (
    input logic                    clk,
    input logic                    rst,
    dispensadora_multiproducto_if.slave bus
);
    localparam int SEL_W = $clog2(N_PROD);
    logic [2:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_PROD-1:0]   dispense_q, dispense_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                coin_reject_q, coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q, busy_d;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] price;
    logic                in_credit, sel_ok, tmo, coin_acc, idle_exp, disp_exp;
    always_comb begin
        in_credit = state_q == S_CREDIT;
        sum       = {1'b0, credit_q} + {1'b0, bus.coin_value};
        sel_ok    = in_credit && bus.sel_valid && int'(bus.sel_idx) < N_PROD && !bus.cancel;
        tmo       = in_credit && idle_exp;
        // a coin only lands when nothing of higher priority claims the cycle
        coin_acc  = bus.coin_valid && sum <= (CREDIT_W+1)'(MAX_CREDIT) &&
                    ((state_q == S_IDLE && bus.coin_value != '0) ||
                     (in_credit && !bus.cancel && !tmo && !sel_ok));
        price     = CREDIT_W'(price_at(TBL_MAX'(bus.price_tbl), int'(sel_q), CREDIT_W));
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        insufficient_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d  = coin_acc ? S_CREDIT : S_IDLE;
                credit_d = coin_acc ? sum[CREDIT_W-1:0] : credit_q;
            end
            S_CREDIT: begin
                state_d  = (bus.cancel || tmo) ? S_REFUND : sel_ok ? S_CHECK : S_CREDIT;
                sel_d    = sel_ok ? bus.sel_idx : sel_q;
                credit_d = coin_acc ? sum[CREDIT_W-1:0] : credit_q;
            end
            S_CHECK: begin
                if (!bus.water_ok || !bus.stock_ok[sel_q]) begin
                    state_d = S_REFUND;
                end else if (credit_q < price) begin
                    state_d        = S_CREDIT;
                    insufficient_d = 1'b1;
                end else begin
                    state_d  = S_DISPENSE;
                    credit_d = credit_q - price;
                end
            end
            S_DISPENSE: state_d = disp_exp ? S_CHANGE : S_DISPENSE;
            S_CHANGE, S_REFUND: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
        // outputs are decoded from the next state so they line up with it
        dispense_d     = state_d == S_DISPENSE ? N_PROD'(1) << sel_d : '0;
        change_valid_d = state_d == S_REFUND || (state_d == S_CHANGE && credit_d != '0);
        change_amt_d   = change_valid_d ? credit_d : '0;
        coin_reject_d  = bus.coin_valid && !coin_acc;
        busy_d         = state_d inside {S_CHECK, S_DISPENSE, S_CHANGE, S_REFUND};
    end
    temporizador_inactividad #(.COUNT(TIMEOUT)) u_idle (
        .clk(clk), .rst(rst), .clear(!in_credit || coin_acc), .enable(in_credit), .expired(idle_exp)
    );
    temporizador_inactividad #(.COUNT(DISP_CYCLES)) u_disp (
        .clk(clk), .rst(rst), .clear(state_q == S_CHECK), .enable(state_q == S_DISPENSE), .expired(disp_exp)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            sel_q          <= '0;
            dispense_q     <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
        end
    end
    assign bus.dispense     = dispense_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/dispensadora_multiproducto.md
# dispensadora_multiproducto

Parametrised beverage-vending controller, the successor to the two-product coffee/tea FSM. Accumulates a running credit from coins of any value, serves one of `N_PROD` products at per-product prices and returns exact change. It also refunds on missing water, empty stock, cancel or inactivity timeout. It sits between the coin acceptor / keypad front end and the dispenser valve and coin-return drivers.

## Interface
- `N_PROD`, 4: number of products; select index width `SEL_W = $clog2(N_PROD)`.
- `CREDIT_W`, 8: width of credit, coin value, price and change.
- `MAX_CREDIT`, 200: credit ceiling; coins that would exceed it are rejected.
- `DISP_CYCLES`, 16: cycles the dispense output is held.
- `TIMEOUT`, 1000: idle cycles in CREDIT before automatic refund.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_value` in CREDIT_W: coin value, sampled with `coin_valid`.
- `sel_valid` in 1: one-cycle selection strobe.
- `sel_idx` in SEL_W: selected product.
- `cancel` in 1: one-cycle user cancel.
- `price_tbl` in N_PROD*CREDIT_W: price of product i at bits [i*CREDIT_W +: CREDIT_W], static while not IDLE.
- `stock_ok` in N_PROD: product i available.
- `water_ok` in 1: water present.
- `dispense` out N_PROD: one-hot valve drive.
- `change_valid` out 1: one-cycle change/refund strobe.
- `change_amt` out CREDIT_W: amount paid out, valid with `change_valid`.
- `coin_reject` out 1: one-cycle pulse, coin returned unaccepted.
- `insufficient` out 1: one-cycle pulse, credit below price.
- `credit` out CREDIT_W: current credit.
- `busy` out 1: high in CHECK, DISPENSE, CHANGE, REFUND.

## Operation
- States: IDLE, CREDIT, CHECK, DISPENSE, CHANGE, REFUND.
- IDLE:
  - accepted coin → CREDIT, `credit = coin_value`.
  - `sel_valid` or `cancel` ignored.
  - `coin_value == 0` is rejected.
- CREDIT:
  - Accepted coin adds to `credit`. If `credit + coin_value > MAX_CREDIT` the coin is rejected: `coin_reject` pulses and `credit` is unchanged. The sum is computed at CREDIT_W+1 bits.
  - `cancel` → REFUND.
  - `sel_valid` with `sel_idx >= N_PROD` is ignored.
  - Valid `sel_valid`: latch `sel_idx` → CHECK.
  - Inactivity counter reaching `TIMEOUT` → REFUND. The counter clears on any accepted coin or selection.
- Priority in CREDIT within one cycle: `cancel` > `sel_valid` > `coin_valid`. A coin arriving on a cancel or selection cycle is rejected.
- CHECK (1 cycle), against the latched selection:
  - `!water_ok` or `!stock_ok[sel]` → REFUND.
  - else `credit < price[sel]` → `insufficient` pulse, back to CREDIT with credit kept.
  - else `credit -= price[sel]` → DISPENSE.
- DISPENSE: `dispense[sel]` high for exactly `DISP_CYCLES` cycles → CHANGE.
- CHANGE:
  - `credit != 0` → `change_valid` with `change_amt = credit`.
  - In all cases `credit` clears → IDLE.
- REFUND: `change_valid` with `change_amt = credit`, credit clears → IDLE.
- Coins in any state other than IDLE/CREDIT are rejected.
- Unused state encodings → IDLE.

## Timing
- Reset (async assert, sync deassert at the flop level) puts the block in IDLE. All outputs are 0 and `credit` = 0.
- Reset asserted mid-DISPENSE drops `dispense` immediately; credit is lost, no refund.
- All outputs are registered (Moore).
- Coin accept → `credit` updates the next cycle.
- Selection → CHECK the next cycle → `dispense` asserted the cycle after CHECK.
- `change_valid` occurs exactly `DISP_CYCLES` cycles after `dispense` rises.
- REFUND `change_valid` follows the triggering event by 1 cycle (cancel) or 2 cycles (CHECK failure).
- Timeout fires on the cycle the counter reaches `TIMEOUT`, with REFUND the next cycle.

## Structure
- Package `vending_pkg`: state enum, default widths, `price_at()` slice function.
- Sub-module `temporizador_inactividad`: parametrised down-counter with `clear`, `enable` and `expired` ports, shared with the dispense-duration count (two instances).

## Test plan
Defaults; prices {10,15,5,20}; all stock and water present.
- Coins 10 then 10, select 1 → `credit` 20 → 5, `dispense` = 0010 for 16 cycles, then `change_valid` with 5.
- Coin 10, select 3 → `insufficient` pulse, state CREDIT, credit 10. Coin 10, select 3 → dispense 1000, no `change_valid`.
- Coins 100+100, then coin 10 → `coin_reject`, credit 200. Select 0 → change 190.
- Coin 10, `stock_ok` = 1110, select 0 → REFUND with `change_amt` 10, no dispense. Repeat with `water_ok` = 0: same result.
- Coin 5, idle 1000 cycles → REFUND 5. Coin together with cancel → `coin_reject` plus refund of the prior credit.
- Coin 10, select 2, `rst` low on 3rd dispense cycle → `dispense` 0 asynchronously, IDLE, credit 0.
